// File: rtl/adc_cal_pkg.sv
// Shared types and defaults for the ADC offset-calibration sequencer.
package adc_cal_pkg;

  localparam int ADC_WAYS_DEF  = 8;
  localparam int ADC_BITS_DEF  = 9;
  localparam int TRIM_BITS_DEF = 8;

  localparam logic [TRIM_BITS_DEF-1:0] TRIM_MID = 8'h80;
  localparam int ADC_MID = 1 << (ADC_BITS_DEF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIAL,
    ST_SETTLE,
    ST_ACCUM,
    ST_DECIDE,
    ST_NEXT
  } cal_state_e;

  // Sum of 2^log2_avg midscale codes; a slice is above midscale when its sum exceeds this.
  function automatic int avg_threshold(input int bits, input int log2_avg);
    return (1 << (bits - 1)) << log2_avg;
  endfunction

endpackage

// File: rtl/adc_cal_avg.sv
// Settle-discard counter plus sample accumulator for one search step.
// Counts SETTLE valid samples, then sums 2^LOG2_AVG samples; holds until clr.
module adc_cal_avg
  import adc_cal_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int LOG2_AVG = 4,
  parameter int SETTLE   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                run,
  input  logic                sample_vld,
  input  logic [ADC_BITS-1:0] sample,
  output logic                settle_done,
  output logic                sum_valid,
  output logic                above_mid
);

  localparam int ACC_W = ADC_BITS + LOG2_AVG;
  localparam int TOTAL = SETTLE + (1 << LOG2_AVG);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(avg_threshold(ADC_BITS, LOG2_AVG));

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;

  // One counter spans both phases, so samples are attributed correctly
  // regardless of when the FSM notices the phase change.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (run && sample_vld && !sum_valid) begin
      cnt <= cnt + CNT_W'(1);
      if (settle_done) acc <= acc + ACC_W'(sample);
    end
  end

  assign settle_done = (cnt >= CNT_W'(SETTLE));
  assign sum_valid   = (cnt == CNT_W'(TOTAL));
  assign above_mid   = (acc > THRESH);

endmodule

// File: rtl/adc_offset_cal_ctrl.sv
// Foreground OSP offset-calibration sequencer: 8-step SAR search per slice, slices 0..N-1.
// Optional ADC_OFFSET_CAL_MASK_EN adds cal_mask input to skip slices.
module adc_offset_cal_ctrl
  import adc_cal_pkg::*;
#(
  parameter int ADC_WAYS  = ADC_WAYS_DEF,
  parameter int ADC_BITS  = ADC_BITS_DEF,
  parameter int TRIM_BITS = TRIM_BITS_DEF,
  parameter int LOG2_AVG  = 4,
  parameter int SETTLE    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          adc_valid,
  input  logic [ADC_WAYS*ADC_BITS-1:0]  adc_data,
  input  logic                          trim_wr_en,
  input  logic [2:0]                    trim_wr_slice,
  input  logic [TRIM_BITS-1:0]          trim_wr_osp,
  input  logic [TRIM_BITS-1:0]          trim_wr_osm,
`ifdef ADC_OFFSET_CAL_MASK_EN
  input  logic [ADC_WAYS-1:0]           cal_mask,
`endif
  output logic [ADC_WAYS*TRIM_BITS-1:0] osp,
  output logic [ADC_WAYS*TRIM_BITS-1:0] osm,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    cur_slice
);

  localparam int BIT_W = $clog2(TRIM_BITS);
  localparam logic [2:0] LAST = 3'(ADC_WAYS - 1);

  cal_state_e           state;
  logic [2:0]           s;
  logic [BIT_W-1:0]     bit_idx;
  logic [TRIM_BITS-1:0] result;
  logic [TRIM_BITS-1:0] restore;
  logic [TRIM_BITS-1:0] trial_mask;
  logic [TRIM_BITS-1:0] result_kept;
  logic [TRIM_BITS-1:0] osp_r [ADC_WAYS];
  logic [TRIM_BITS-1:0] osm_r [ADC_WAYS];
  logic [ADC_BITS-1:0]  sample;
  logic                 skip;
  logic                 settle_done;
  logic                 sum_valid;
  logic                 above_mid;

`ifdef ADC_OFFSET_CAL_MASK_EN
  logic [ADC_WAYS-1:0] mask_q;
  assign skip = mask_q[s];
`else
  assign skip = 1'b0;
`endif

  assign trial_mask  = TRIM_BITS'(1) << bit_idx;
  assign result_kept = above_mid ? (result | trial_mask) : result;
  assign sample      = adc_data[int'(s)*ADC_BITS +: ADC_BITS];

  adc_cal_avg #(
    .ADC_BITS (ADC_BITS),
    .LOG2_AVG (LOG2_AVG),
    .SETTLE   (SETTLE)
  ) u_avg (
    .clock       (clock),
    .reset       (reset),
    .clr         (state == ST_TRIAL),
    .run         ((state == ST_SETTLE) || (state == ST_ACCUM)),
    .sample_vld  (adc_valid),
    .sample      (sample),
    .settle_done (settle_done),
    .sum_valid   (sum_valid),
    .above_mid   (above_mid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      s       <= '0;
      bit_idx <= BIT_W'(TRIM_BITS - 1);
      result  <= '0;
      restore <= TRIM_BITS'(TRIM_MID);
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < ADC_WAYS; i++) begin
        osp_r[i] <= TRIM_BITS'(TRIM_MID);
        osm_r[i] <= TRIM_BITS'(TRIM_MID);
      end
`ifdef ADC_OFFSET_CAL_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Only these states have a modified osp[s]; in LOAD/NEXT it is already correct.
        if (state inside {ST_TRIAL, ST_SETTLE, ST_ACCUM, ST_DECIDE}) osp_r[s] <= restore;
        state <= ST_IDLE;
        s     <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (trim_wr_en) begin
              osp_r[trim_wr_slice] <= trim_wr_osp;
              osm_r[trim_wr_slice] <= trim_wr_osm;
            end
            if (start && !abort) begin
              state <= ST_LOAD;
              s     <= '0;
              busy  <= 1'b1;
`ifdef ADC_OFFSET_CAL_MASK_EN
              mask_q <= cal_mask;
`endif
            end
          end
          ST_LOAD: begin
            if (skip) begin
              if (s == LAST) begin
                state <= ST_IDLE;
                s     <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                s <= s + 3'd1;
              end
            end else begin
              restore <= osp_r[s];
              result  <= '0;
              bit_idx <= BIT_W'(TRIM_BITS - 1);
              state   <= ST_TRIAL;
            end
          end
          ST_TRIAL: begin
            osp_r[s] <= result | trial_mask;
            state    <= ST_SETTLE;
          end
          ST_SETTLE: if (settle_done) state <= ST_ACCUM;
          ST_ACCUM:  if (sum_valid) state <= ST_DECIDE;
          ST_DECIDE: begin
            result <= result_kept;
            if (bit_idx == '0) begin
              osp_r[s] <= result_kept;
              state    <= ST_NEXT;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
              state   <= ST_TRIAL;
            end
          end
          ST_NEXT: begin
            if (s == LAST) begin
              state <= ST_IDLE;
              s     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              s     <= s + 3'd1;
              state <= ST_LOAD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < ADC_WAYS; i++) begin : g_pack
    assign osp[i*TRIM_BITS +: TRIM_BITS] = osp_r[i];
    assign osm[i*TRIM_BITS +: TRIM_BITS] = osm_r[i];
  end

  assign cur_slice = s;

endmodule
